mips_reg_responder: RTL and testbench
=====================================

# mips_reg_responder

Register-file responder for the single-cycle R-type core. It accepts operand-read requests (rs, rt) together with a destination reservation (rd), returns both operand values one cycle later, and takes result write-backs. A busy-bit scoreboard stalls requests that would read or overwrite a register whose result is still outstanding. Register 0 reads as zero.

## Interface
- DATA_W, 32, register data width
- NREGS, 32, number of architectural registers; the address width is log2(NREGS) = 5
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  operand request present
- req_ready  out  1  request can be accepted this cycle
- req_rs, req_rt  in  5  source register addresses
- req_rd  in  5  destination register address
- req_rd_we  in  1  request reserves rd for a later write-back
- rsp_valid  out  1  operand response valid; single-cycle pulse, no backpressure
- rsp_rs_data, rsp_rt_data  out  DATA_W  operand values
- wb_valid  in  1  write-back present
- wb_addr  in  5  write-back register
- wb_data  in  DATA_W  write-back value
- busy_mask  out  NREGS  scoreboard; bit i = register i has a write pending
- err  out  1  sticky error flag

## Operation
- FSM states: INIT, RUN.
  - reset forces INIT with the clear counter at 0.
  - INIT writes 0 to register[cnt] and increments cnt once per cycle. After register NREGS-1 is written, the next state is RUN.
- req_ready is 1 only when all of these hold:
  - the FSM is in RUN and reset is low;
  - the rs hazard is clear: (busy[rs]=0 or rs=0 or a same-cycle wb targets rs);
  - the same rs hazard rule holds for rt;
  - the WAW check passes: (!req_rd_we or rd=0 or busy[rd]=0 or a same-cycle wb targets rd).
- A request is accepted when req_valid && req_ready. On accept:
  - operands are captured. Source order for each operand: 0 if the address is 0; else wb_data if wb_valid and wb_addr matches; else the array value.
  - if req_rd_we and rd≠0, busy[rd] is set.
- Write-back, valid only in RUN:
  - if wb_addr≠0, the register is written;
  - busy[wb_addr] is cleared;
  - if busy[wb_addr] was 0, err is set (unreserved write-back). The write still occurs.
- wb_valid during INIT is ignored and sets err.
- Same-cycle wb clear and accept reservation on the same register: the reservation wins, so busy ends at 1.
- Writes to register 0 are discarded. busy[0] is always 0.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rs_data=0, rsp_rt_data=0, busy_mask=0, err=0;
  - the FSM is in INIT, and all registers are 0 once INIT completes.
- Reset asserted mid-operation: all reservations are dropped, any in-flight response is cancelled (rsp_valid=0 next cycle), and INIT restarts.

## Timing
- INIT lasts exactly NREGS cycles after reset deasserts. req_ready can first be 1 on cycle NREGS (counting the first non-reset cycle as 0).
- Response latency: rsp_valid and the data are registered, and appear the cycle after accept. Back-to-back accepts give back-to-back rsp_valid pulses.
- Write-back latency: a wb in cycle N is visible to array reads from cycle N+1, and to the bypass in cycle N.
- busy_mask is registered: a set or clear on edge N is visible from cycle N+1.
- req_ready is combinational from the request, wb and busy inputs. The requester must not make req_valid depend on req_ready.

## Structure
- Shared package mips_pkg:
  - DATA_W, REG_ADDR_W, NREGS;
  - the funct constants (ADD, ADDU, SUB, AND, OR, SRA, SRL, SLL, SLTU);
  - the state enum {INIT, RUN}.
- Sub-module mips_scoreboard holds the busy bits, the set/clear logic with the reserve-wins rule, and the combinational hazard outputs.
- The top level holds the register array, the FSM, the bypass muxes and the response registers.

## Test plan
- Reset, then idle: req_ready=0 for cycles 0–31 and 1 at cycle 32. A read of r5/r6 returns 0/0 one cycle after accept.
- wb r3=0x0000_00AA with no reservation → err=1, r3 updated. A later read of rs=3 returns 0x0000_00AA.
- Accept rd=7 with req_rd_we=1, then request rs=7 → req_ready=0. wb r7=0x1234 in the same cycle as the retried request → accepted, and rsp_rs_data=0x1234 on the next cycle.
- wb r0=0xFFFF_FFFF, then read rs=0, rt=0 → both 0. busy_mask[0] stays 0 and err stays 0.
- Simultaneous wb to r9 (pending) and a new accept with rd=9, rd_we=1 → busy_mask[9]=1 next cycle, err=0.
- Reset asserted the cycle after an accept with rd=4 reserved → no rsp_valid, busy_mask=0. INIT restarts and runs 32 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the R-type core register responder.
// Widths, ALU funct codes and the responder FSM encoding.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = $clog2(NREGS);

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_t;

  typedef enum logic [5:0] {
    SLL  = 6'h00,
    SRL  = 6'h02,
    SRA  = 6'h03,
    ADD  = 6'h20,
    ADDU = 6'h21,
    SUB  = 6'h22,
    AND  = 6'h24,
    OR   = 6'h25,
    SLTU = 6'h2b
  } funct_t;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

endpackage

// File: rtl/mips_reg_responder_if.sv
// Operand request, response and write-back bundle of the responder.
// master = issuing core, slave = register responder.
interface mips_reg_responder_if;
  import mips_pkg::*;

  logic             req_valid;
  logic             req_ready;
  reg_t             req_rs;
  reg_t             req_rt;
  reg_t             req_rd;
  logic             req_rd_we;
  logic             rsp_valid;
  word_t            rsp_rs_data;
  word_t            rsp_rt_data;
  logic             wb_valid;
  reg_t             wb_addr;
  word_t            wb_data;
  logic [NREGS-1:0] busy_mask;
  logic             err;

  modport master (
    output req_valid, req_rs, req_rt,
    output req_rd, req_rd_we,
    output wb_valid, wb_addr, wb_data,
    input  req_ready, rsp_valid,
    input  rsp_rs_data, rsp_rt_data,
    input  busy_mask, err
  );

  modport slave (
    input  req_valid, req_rs, req_rt,
    input  req_rd, req_rd_we,
    input  wb_valid, wb_addr, wb_data,
    output req_ready, rsp_valid,
    output rsp_rs_data, rsp_rt_data,
    output busy_mask, err
  );

endinterface

// File: rtl/mips_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register,
// plus RAW/WAW hazard evaluation for the incoming request.
module mips_scoreboard
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  reg_t             rs,
  input  reg_t             rt,
  input  reg_t             rd,
  input  logic             rd_we,
  input  logic             set_en,
  input  logic             wb_en,
  input  reg_t             wb_addr,
  output logic [NREGS-1:0] busy,
  output logic             hz_ok,
  output logic             wb_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             rs_ok;
  logic             rt_ok;
  logic             waw_ok;

  assign busy    = busy_q;
  assign wb_busy = busy_q[wb_addr];

  // A write-back landing this cycle resolves the hazard it targets
  assign rs_ok = !busy_q[rs] || (rs == '0)
              || (wb_en && (wb_addr == rs));
  assign rt_ok = !busy_q[rt] || (rt == '0)
              || (wb_en && (wb_addr == rt));
  assign waw_ok = !rd_we || (rd == '0) || !busy_q[rd]
               || (wb_en && (wb_addr == rd));

  assign hz_ok = rs_ok && rt_ok && waw_ok;

  // Set after clear so a same-cycle reservation wins
  always_comb begin
    busy_d = busy_q;
    if (wb_en)
      busy_d[wb_addr] = 1'b0;
    if (set_en && rd_we && (rd != '0))
      busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

endmodule

// File: rtl/mips_reg_responder.sv
// Register-file responder: zeroing FSM, register array, bypass,
// registered operand response and sticky write-back error.
module mips_reg_responder
  import mips_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  mips_reg_responder_if.slave bus
);

  state_t           state_q;
  state_t           state_d;
  reg_t             cnt_q;
  reg_t             cnt_d;
  word_t            regs [NREGS];
  logic             run;
  logic             wb_en;
  logic             accept;
  logic             hz_ok;
  logic             wb_busy;
  logic             err_set;
  logic [NREGS-1:0] busy;
  word_t            rs_val;
  word_t            rt_val;
  logic             rsp_valid_q;
  word_t            rsp_rs_q;
  word_t            rsp_rt_q;
  logic             err_q;

  assign run    = (state_q == RUN);
  assign wb_en  = run && bus.wb_valid;
  assign accept = bus.req_valid && bus.req_ready;

  assign bus.req_ready   = run && !reset && hz_ok;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rs_data = rsp_rs_q;
  assign bus.rsp_rt_data = rsp_rt_q;
  assign bus.busy_mask   = busy;
  assign bus.err         = err_q;

  mips_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .rs      (bus.req_rs),
    .rt      (bus.req_rt),
    .rd      (bus.req_rd),
    .rd_we   (bus.req_rd_we),
    .set_en  (accept),
    .wb_en   (wb_en),
    .wb_addr (bus.wb_addr),
    .busy    (busy),
    .hz_ok   (hz_ok),
    .wb_busy (wb_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == REG_ADDR_W'(NREGS - 1))
          state_d = RUN;
      end
      RUN: ;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run)
        regs[cnt_q] <= '0;
      else if (wb_en && (bus.wb_addr != '0))
        regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    rs_val = regs[bus.req_rs];
    if (bus.req_rs == '0)
      rs_val = '0;
    else if (wb_en && (bus.wb_addr == bus.req_rs))
      rs_val = bus.wb_data;
  end

  always_comb begin
    rt_val = regs[bus.req_rt];
    if (bus.req_rt == '0)
      rt_val = '0;
    else if (wb_en && (bus.wb_addr == bus.req_rt))
      rt_val = bus.wb_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rs_q    <= '0;
      rsp_rt_q    <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_rs_q <= rs_val;
        rsp_rt_q <= rt_val;
      end
    end
  end

  // r0 write-backs are expected no-ops, not unreserved writes
  assign err_set = bus.wb_valid
                && (!run || ((bus.wb_addr != '0) && !wb_busy));

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (err_set)
      err_q <= 1'b1;
  end

endmodule

// File: tb/tb_mips_reg_responder.sv
// Bench for mips_reg_responder: directed scenarios then random
// traffic, all checked against a behavioural register-file model.
module tb_mips_reg_responder;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mips_reg_responder_if bus ();

  mips_reg_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  bit          m_err;
  int          init_left;
  bit          m_rv;
  logic [31:0] m_rs;
  logic [31:0] m_rt;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit hit(logic [4:0] a);
    return bus.wb_valid && (bus.wb_addr == a);
  endfunction

  function automatic bit m_ready();
    if (reset || init_left != 0) return 1'b0;
    if (m_busy[bus.req_rs] && bus.req_rs != 0
        && !hit(bus.req_rs)) return 1'b0;
    if (m_busy[bus.req_rt] && bus.req_rt != 0
        && !hit(bus.req_rt)) return 1'b0;
    if (bus.req_rd_we && bus.req_rd != 0
        && m_busy[bus.req_rd] && !hit(bus.req_rd)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 0) return 32'd0;
    if (hit(a)) return bus.wb_data;
    return m_regs[a];
  endfunction

  task automatic m_reset();
    m_busy = '0;
    m_err = 1'b0;
    m_rv = 1'b0;
    init_left = NREGS;
    foreach (m_regs[i]) m_regs[i] = '0;
  endtask

  // Check outputs mid-cycle, then advance the model over the edge
  task automatic step();
    bit rdy;
    #3;
    rdy = m_ready();
    check("req_ready", bus.req_ready, rdy);
    check("rsp_valid", bus.rsp_valid, m_rv);
    if (m_rv) begin
      check("rsp_rs_data", bus.rsp_rs_data, m_rs);
      check("rsp_rt_data", bus.rsp_rt_data, m_rt);
    end
    check("busy_mask", bus.busy_mask, m_busy);
    check("err", bus.err, m_err);
    if (reset) begin
      m_reset();
    end else if (init_left > 0) begin
      init_left--;
      m_rv = 1'b0;
      if (bus.wb_valid) m_err = 1'b1;
    end else begin
      m_rv = bus.req_valid && rdy;
      if (m_rv) begin
        m_rs = m_read(bus.req_rs);
        m_rt = m_read(bus.req_rt);
      end
      if (bus.wb_valid) begin
        if (bus.wb_addr != 0) begin
          if (!m_busy[bus.wb_addr]) m_err = 1'b1;
          m_regs[bus.wb_addr] = bus.wb_data;
        end
        m_busy[bus.wb_addr] = 1'b0;
      end
      if (m_rv && bus.req_rd_we && bus.req_rd != 0)
        m_busy[bus.req_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_rs = '0;
    bus.req_rt = '0;
    bus.req_rd = '0;
    bus.req_rd_we = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
  endtask

  task automatic req(logic [4:0] rs, logic [4:0] rt,
                     logic [4:0] rd, logic we);
    bus.req_valid = 1'b1;
    bus.req_rs = rs;
    bus.req_rt = rt;
    bus.req_rd = rd;
    bus.req_rd_we = we;
  endtask

  task automatic wb(logic [4:0] a, logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  initial begin
    int a;
    idle();
    reset = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    step();
    check("rst_rs_data", bus.rsp_rs_data, 0);
    check("rst_rt_data", bus.rsp_rt_data, 0);
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) step();
    check("ready_c32", bus.req_ready, 1);

    req(5, 6, 0, 0);
    step();
    check("r5r6_valid", bus.rsp_valid, 1);
    check("r5_data", bus.rsp_rs_data, 0);
    check("r6_data", bus.rsp_rt_data, 0);

    idle();
    wb(0, 32'hFFFF_FFFF);
    step();
    idle();
    req(0, 0, 0, 0);
    step();
    check("r0_rs", bus.rsp_rs_data, 0);
    check("r0_rt", bus.rsp_rt_data, 0);
    check("r0_busy", bus.busy_mask[0], 0);
    check("r0_err", bus.err, 0);

    idle();
    req(1, 2, 9, 1);
    step();
    idle();
    req(1, 2, 9, 1);
    wb(9, 32'h99);
    step();
    check("r9_reserve_wins", bus.busy_mask[9], 1);
    check("r9_err", bus.err, 0);

    idle();
    req(0, 0, 7, 1);
    step();
    idle();
    req(7, 0, 0, 0);
    #1;
    check("r7_stall", bus.req_ready, 0);
    step();
    wb(7, 32'h1234);
    step();
    check("r7_bypass_v", bus.rsp_valid, 1);
    check("r7_bypass", bus.rsp_rs_data, 32'h1234);

    idle();
    wb(3, 32'h0000_00AA);
    step();
    check("r3_err", bus.err, 1);
    idle();
    req(3, 0, 0, 0);
    step();
    check("r3_read", bus.rsp_rs_data, 32'hAA);

    idle();
    req(0, 0, 4, 1);
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", bus.busy_mask, 0);
    wb(1, 32'h5);
    step();
    idle();
    for (int i = 1; i < NREGS; i++) step();
    check("reinit_ready", bus.req_ready, 1);
    check("init_wb_err", bus.err, 1);

    for (int n = 0; n < 1500; n++) begin
      idle();
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) != 0)
        req(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      a = $urandom_range(0, 9);
      if (a < 5 && m_busy != 0) begin
        do a = $urandom_range(1, 31); while (!m_busy[a]);
        wb(5'(a), $urandom);
      end else if (a == 5) begin
        wb(5'($urandom_range(0, 31)), $urandom);
      end
      step();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
